// File: rtl/echo_pkg.sv
// Shared writeback definitions: datapath width, load funct3 encodings,
// register x0 and the writeback channel select.
package echo_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ld_align.sv
// Load data alignment: picks the byte/halfword addressed by ld_addr_lo out of
// the raw memory word and sign- or zero-extends it. Unknown funct3 values are
// passed through as a full word and flagged.
module ld_align
  import echo_pkg::*;
(
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  output logic [XLEN-1:0] ld_val,
  output logic            ld_illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Extract the addressed lane and extend it according to the load type.
  always_comb begin
    byte_sel   = ld_word[7:0];
    half_sel   = ld_word[15:0];
    ld_val     = ld_word;
    ld_illegal = 1'b0;

    unique case (ld_addr_lo)
      2'd0: byte_sel = ld_word[7:0];
      2'd1: byte_sel = ld_word[15:8];
      2'd2: byte_sel = ld_word[23:16];
      2'd3: byte_sel = ld_word[31:24];
      default: byte_sel = ld_word[7:0];
    endcase

    // Bit 0 of the address is ignored for halfwords.
    half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_funct3)
      F3_LB:   ld_val = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      F3_LH:   ld_val = {{(XLEN - 16){half_sel[15]}}, half_sel};
      F3_LW:   ld_val = ld_word;
      F3_LBU:  ld_val = {{(XLEN - 8){1'b0}}, byte_sel};
      F3_LHU:  ld_val = {{(XLEN - 16){1'b0}}, half_sel};
      default: begin
        ld_val     = ld_word;
        ld_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: round-robin arbitration between the ALU and load result
// channels onto the single regfile write port, with registered write outputs,
// a retired-result counter and an optional same-cycle bypass.
// Optional feature macro: WB_FORWARD_EN (enables the rs1/rs2 bypass outputs).
module wb_unit
  import echo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  output logic            write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_val,
  output logic            ld_err,
  output logic [31:0]     retire_cnt,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_val
);

  wb_src_e         rr_last_q, rr_last_d;
  logic            alu_grant, ld_grant, accept;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_val;
  logic [XLEN-1:0] ld_val;
  logic            ld_illegal;

  ld_align u_ld_align (
    .ld_word    (ld_word),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_val     (ld_val),
    .ld_illegal (ld_illegal)
  );

  // Grant: uncontested valid wins; on conflict the channel not granted last wins.
  // Readies are forced low while reset is asserted.
  always_comb begin
    alu_grant = rst_n & alu_valid & (~ld_valid | (rr_last_q == WB_SRC_LD));
    ld_grant  = rst_n & ld_valid & (~alu_valid | (rr_last_q == WB_SRC_ALU));
    rr_last_d = rr_last_q;
    if (alu_valid && ld_valid) begin
      rr_last_d = ld_grant ? WB_SRC_LD : WB_SRC_ALU;
    end
    accept  = alu_grant | ld_grant;
    sel_rd  = ld_grant ? ld_rd : alu_rd;
    sel_val = ld_grant ? ld_val : alu_val;
  end

  assign alu_ready = alu_grant;
  assign ld_ready  = ld_grant;

  // Output registers, arbitration history and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= WB_SRC_ALU;
      write_en   <= 1'b0;
      rd         <= REG_X0;
      rd_val     <= '0;
      ld_err     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      // x0 writes retire normally but never strobe the regfile.
      write_en  <= accept && (sel_rd != REG_X0);
      ld_err    <= ld_grant & ld_illegal;
      if (accept) begin
        rd         <= sel_rd;
        rd_val     <= sel_val;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Bypass from the registered write port; write_en already excludes x0.
  always_comb begin
    fwd1_hit = write_en && (rd == rs1);
    fwd2_hit = write_en && (rd == rs2);
    fwd_val  = rd_val;
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};

  // Bypass disabled: outputs tied off, ports kept for a uniform interface.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd2_hit = 1'b0;
    fwd_val  = '0;
  end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: table-driven load formatting, directed
// arbitration/x0/error/bypass/reset sequences, and a randomized phase
// checked against a transaction-level reference model.
module tb_wb_unit;

  logic        clk, rst_n;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, rd, rs1, rs2;
  logic [31:0] alu_val, ld_word, rd_val, retire_cnt, fwd_val;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        write_en, ld_err, fwd1_hit, fwd2_hit;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic        exp_we, exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_cnt;
  bit          last_was_ld;  // winner of the most recent conflict

  wb_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_val    (alu_val),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_word    (ld_word),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .write_en   (write_en),
    .rd         (rd),
    .rd_val     (rd_val),
    .ld_err     (ld_err),
    .retire_cnt (retire_cnt),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd_val    (fwd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result computed from the ISA rules with plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [2:0] f3);
    return !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction

  function automatic logic exp_hit(input logic [4:0] rs);
`ifdef WB_FORWARD_EN
    return exp_we && (exp_rd == rs);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_fwd();
`ifdef WB_FORWARD_EN
    return exp_val;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".write_en"}, 32'(write_en), 32'(exp_we));
    chk({tag, ".rd"}, 32'(rd), 32'(exp_rd));
    chk({tag, ".rd_val"}, rd_val, exp_val);
    chk({tag, ".ld_err"}, 32'(ld_err), 32'(exp_err));
    chk({tag, ".retire_cnt"}, retire_cnt, exp_cnt);
    chk({tag, ".fwd1_hit"}, 32'(fwd1_hit), 32'(exp_hit(rs1)));
    chk({tag, ".fwd2_hit"}, 32'(fwd2_hit), 32'(exp_hit(rs2)));
    chk({tag, ".fwd_val"}, fwd_val, exp_fwd());
  endtask

  // Model update for an accepted (or absent) transaction.
  task automatic model_accept(input bit is_alu, input bit is_ld, input logic [4:0] r,
                              input logic [31:0] v, input bit err);
    exp_err = 1'b0;
    exp_we  = 1'b0;
    if (is_alu || is_ld) begin
      exp_rd  = r;
      exp_val = v;
      exp_we  = (r != 5'd0);
      exp_err = is_ld && err;
      exp_cnt = exp_cnt + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_we = 0; exp_err = 0; exp_rd = 0; exp_val = 0; exp_cnt = 0;
    last_was_ld = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        err;
  } ld_vec_t;

  ld_vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b000, 2'd3, 32'h80FF7F01, 5'd1, 32'hFFFFFF80, 1'b0};
    vecs[1] = '{3'b101, 2'd2, 32'h80FF7F01, 5'd2, 32'h000080FF, 1'b0};
    vecs[2] = '{3'b001, 2'd0, 32'h80FF7F01, 5'd3, 32'h00007F01, 1'b0};
    vecs[3] = '{3'b100, 2'd1, 32'h80FF7F01, 5'd4, 32'h0000007F, 1'b0};
    vecs[4] = '{3'b000, 2'd2, 32'h80FF7F01, 5'd6, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{3'b001, 2'd3, 32'h80FF7F01, 5'd7, 32'hFFFF80FF, 1'b0};
    vecs[6] = '{3'b101, 2'd1, 32'h80FF7F01, 5'd8, 32'h00007F01, 1'b0};
    vecs[7] = '{3'b010, 2'd3, 32'h80FF7F01, 5'd9, 32'h80FF7F01, 1'b0};
    vecs[8] = '{3'b011, 2'd2, 32'h12345678, 5'd10, 32'h12345678, 1'b1};
    vecs[9] = '{3'b110, 2'd1, 32'hCAFEF00D, 5'd11, 32'hCAFEF00D, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    alu_rd = 0; alu_val = 0; ld_rd = 0; ld_word = 0; ld_funct3 = 0; ld_addr_lo = 0;
    rs1 = 5'd31; rs2 = 5'd30;
    exp_we = 0; exp_err = 0; exp_rd = 0; exp_val = 0; exp_cnt = 0; last_was_ld = 0;
    #12;
    chk("reset.alu_ready", 32'(alu_ready), 32'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    step();

    // Single ALU result.
    alu_valid = 1; alu_rd = 5'd5; alu_val = 32'hDEADBEEF;
    #1;
    chk("alu1.alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    model_accept(1, 0, 5'd5, 32'hDEADBEEF, 0);
    check_outputs("alu1");
    step();
    model_accept(0, 0, 0, 0, 0);
    chk("alu1.idle_we", 32'(write_en), 32'd0);
    chk("alu1.hold_val", rd_val, 32'hDEADBEEF);

    // Table-driven load formatting.
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_rd = vecs[i].dst; ld_word = vecs[i].word;
      ld_funct3 = vecs[i].f3; ld_addr_lo = vecs[i].lo;
      #1;
      chk($sformatf("ld%0d.ld_ready", i), 32'(ld_ready), 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      model_accept(0, 1, vecs[i].dst, vecs[i].val, vecs[i].err);
      check_outputs($sformatf("ld%0d", i));
      step();
      model_accept(0, 0, 0, 0, 0);
      chk($sformatf("ld%0d.err_pulse_end", i), 32'(ld_err), 32'd0);
    end

    // Sustained conflict: LD, ALU, LD, ALU.
    alu_valid = 1; alu_rd = 5'd12; alu_val = 32'h0000AAAA;
    ld_valid = 1; ld_rd = 5'd13; ld_word = 32'h0000BBBB; ld_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d.ld_ready", i), 32'(ld_ready), 32'((i % 2) == 0));
      chk($sformatf("rr%0d.alu_ready", i), 32'(alu_ready), 32'((i % 2) == 1));
      @(posedge clk); #1;
      if ((i % 2) == 0) model_accept(0, 1, 5'd13, 32'h0000BBBB, 0);
      else model_accept(1, 0, 5'd12, 32'h0000AAAA, 0);
      chk($sformatf("rr%0d.rd", i), 32'(rd), 32'(exp_rd));
      chk($sformatf("rr%0d.cnt", i), retire_cnt, exp_cnt);
    end
    last_was_ld = 1'b0;
    idle_inputs();
    step();
    model_accept(0, 0, 0, 0, 0);

    // Write to x0: retires without a strobe.
    alu_valid = 1; alu_rd = 5'd0; alu_val = 32'h1234;
    step();
    idle_inputs();
    model_accept(1, 0, 5'd0, 32'h1234, 0);
    check_outputs("x0");

    // Bypass on rd=30.
    rs1 = 5'd31; rs2 = 5'd30;
    alu_valid = 1; alu_rd = 5'd30; alu_val = 32'd3;
    step();
    idle_inputs();
    model_accept(1, 0, 5'd30, 32'd3, 0);
    check_outputs("fwd");

    // Asynchronous reset while write_en is high.
    alu_valid = 1; alu_rd = 5'd7; alu_val = 32'h77;
    step();
    model_accept(1, 0, 5'd7, 32'h77, 0);
    chk("arst.pre_we", 32'(write_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.we", 32'(write_en), 32'd0);
    chk("arst.cnt", retire_cnt, 32'd0);
    chk("arst.alu_ready", 32'(alu_ready), 32'd0);
    idle_inputs();
    do_reset();
    step();
    ld_valid = 1; ld_rd = 5'd14; ld_word = 32'h55; ld_funct3 = 3'b010;
    alu_valid = 1; alu_rd = 5'd15; alu_val = 32'h66;
    #1;
    chk("arst.first_ld_ready", 32'(ld_ready), 32'd1);
    chk("arst.first_alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clk); #1;
    model_accept(0, 1, 5'd14, 32'h55, 0);
    last_was_ld = 1'b1;
    idle_inputs();
    check_outputs("arst.first");

    // Randomized phase against the reference model.
    begin
      bit          pa, pl, ga, gl;
      logic [4:0]  ard, lrd;
      logic [31:0] av, lw;
      logic [2:0]  lf3;
      logic [1:0]  llo;
      pa = 0; pl = 0;
      ard = 0; lrd = 0; av = 0; lw = 0; lf3 = 0; llo = 0;
      for (int c = 0; c < 400; c++) begin
        if (!pa && ($urandom_range(0, 2) != 0)) begin
          pa = 1; ard = 5'($urandom_range(0, 7)); av = $urandom;
        end
        if (!pl && ($urandom_range(0, 2) != 0)) begin
          pl = 1; lrd = 5'($urandom_range(0, 7)); lw = $urandom;
          lf3 = 3'($urandom_range(0, 7)); llo = 2'($urandom_range(0, 3));
        end
        alu_valid = pa; alu_rd = ard; alu_val = av;
        ld_valid = pl; ld_rd = lrd; ld_word = lw; ld_funct3 = lf3; ld_addr_lo = llo;
        rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        // Only one result per cycle; on conflict the previous loser goes first.
        ga = pa && (!pl || last_was_ld);
        gl = pl && (!pa || !last_was_ld);
        #1;
        chk("rand.alu_ready", 32'(alu_ready), 32'(ga));
        chk("rand.ld_ready", 32'(ld_ready), 32'(gl));
        @(posedge clk); #1;
        if (pa && pl) last_was_ld = gl;
        if (ga) model_accept(1, 0, ard, av, 0);
        else if (gl) model_accept(0, 1, lrd, ref_load(lw, lf3, llo), ref_illegal(lf3));
        else model_accept(0, 0, 0, 0, 0);
        check_outputs("rand");
        if (ga) pa = 0;
        if (gl) pl = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback stage that owns the single write port of `regfile`. It accepts completed results from the ALU and the load unit over valid/ready channels, and arbitrates between them round-robin on conflict. It aligns and sign/zero-extends load data, and drives registered `write_en`/`rd`/`rd_val` into the register file. An optional bypass lets decode-stage readers see the value being written this cycle.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  5  destination register
- `alu_val`  in  XLEN  result
- `ld_valid`  in  1  load result available
- `ld_ready`  out  1  load accepted when high with `ld_valid`
- `ld_rd`  in  5  destination register
- `ld_word`  in  XLEN  raw aligned memory word
- `ld_funct3`  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- `ld_addr_lo`  in  2  byte address bits [1:0]
- `write_en`  out  1  regfile write strobe
- `rd`  out  5  regfile write address
- `rd_val`  out  XLEN  regfile write data
- `ld_err`  out  1  one-cycle pulse, illegal `ld_funct3` was accepted
- `retire_cnt`  out  32  count of accepted results
- `rs1`, `rs2`  in  5  decode read addresses (bypass)
- `fwd1_hit`, `fwd2_hit`  out  1  bypass match for rs1/rs2
- `fwd_val`  out  XLEN  bypass data

## Operation
- Grant: a channel whose valid is high is granted if the other channel is idle. If both are valid, the grant goes to the channel opposite `rr_last`, and `rr_last` is updated to the granted channel. `rr_last` changes only on conflicts; its reset value is ALU, so the load channel wins the first conflict.
- Ready is combinational: `ld_ready` = grant to load; `alu_ready` = grant to ALU. Neither ready is high without its own valid. Ungranted inputs must hold stable; no internal buffering.
- Accepted transaction: register `rd` ← channel rd; `rd_val` ← ALU value, or the formatted load value; `write_en` ← (rd ≠ 0). A write to x0 is accepted and counted, but `write_en` stays low.
- No accept in a cycle: `write_en` ← 0; `rd`/`rd_val` hold their previous values.
- Load formatting: byte selected by `ld_addr_lo`, halfword by `ld_addr_lo[1]`; `ld_addr_lo[0]` is ignored for halfwords. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through and ignores `ld_addr_lo`.
- Illegal funct3 (011, 110, 111): the word is treated as LW and `ld_err` pulses on the same cycle `write_en` would.
- `retire_cnt` increments by 1 per accepted transaction, x0 writes included, and wraps from 2^32−1 to 0.
- Reset (async, any time): `write_en`=0, `rd`=0, `rd_val`=0, `ld_err`=0, `retire_cnt`=0, `rr_last`=ALU. Readies fall to 0 while `rst_n` is low. A transaction in flight at reset assertion is dropped.

## Timing
- Latency: 1 cycle. An accept at edge N gives `write_en`/`rd`/`rd_val` valid after edge N; the regfile commits at edge N+1.
- Throughput: one result per cycle. Under a sustained conflict, each channel gets every other cycle.
- Bypass is combinational from registered outputs and `rs1`/`rs2`, so it is valid in the same cycle `write_en` is high.

## Configuration
- `WB_FORWARD_EN` defined: `fwdN_hit` = `write_en` && (`rd` == `rsN`); `fwd_val` = `rd_val`. The hit is never asserted for x0, because `write_en` is already low for x0.
- Undefined: `fwd1_hit`, `fwd2_hit` and `fwd_val` are tied to 0 and `rs1`/`rs2` are unused. Ports remain present so the interface is identical in both builds.

## Structure
- Shared package `echo_pkg`: `XLEN`, load funct3 encodings (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`), `REG_X0`, and a channel-select enum (`WB_SRC_ALU`, `WB_SRC_LD`).
- Sub-module `ld_align`: combinational extract/extend of `ld_word` by `ld_funct3`/`ld_addr_lo`, plus an illegal-funct3 flag.
- Top level holds the arbiter, `rr_last`, output registers, counter and bypass.

## Test plan
- Reset, then an ALU result `rd`=5, value 0xDEADBEEF → `write_en`=1, `rd`=5, `rd_val`=0xDEADBEEF one cycle later; `retire_cnt`=1.
- Load LB, `ld_word`=0x80FF7F01, `ld_addr_lo`=3 → `rd_val`=0xFFFFFF80. Same word with LHU, `ld_addr_lo`=2 → 0x000080FF. LH, `ld_addr_lo`=0 → 0x00007F01.
- ALU and load both valid for 4 cycles → grants go LD, ALU, LD, ALU; each ready is high only on its granted cycle.
- ALU result to rd=0, value 0x1234 → `write_en` stays 0, `retire_cnt` increments. Load with funct3=011 → `ld_err` pulses for 1 cycle and `rd_val`=`ld_word`.
- With `WB_FORWARD_EN`: write rd=30, value 3, with `rs1`=31, `rs2`=30 → `fwd2_hit`=1, `fwd_val`=3, `fwd1_hit`=0. Without the macro → all bypass outputs 0.
- Drop `rst_n` asynchronously mid-stream, with `write_en`=1 → `write_en` and `retire_cnt` go to 0 before the next edge. After release, the first conflict is granted to load.
